// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the sequential multiply/divide unit: FSM states,
// op encodings and default sizing.
package mdu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdu_state_e;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int MDU_WIDTH = 32;
  localparam int MDU_ITERS = MDU_WIDTH;

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the control FSM and the multiply/divide unit.
interface mdu_if
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, done, div_zero, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, div_zero, hi, lo);
endinterface

// File: rtl/mult_div_unit.sv
// Sequential signed mult/div producing the HI/LO pair; magnitudes are
// iterated unsigned for WIDTH cycles and signs are applied in FIX.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input logic  clk,
  input logic  reset,
  mdu_if.slave bus
);

  mdu_state_e         state_r, state_next_s;
  logic [5:0]         cnt_r;
  logic               op_r, sign_a_r, sign_b_r, dz_r;
  logic [WIDTH-1:0]   opnd_r, hi_r, lo_r;
  logic [2*WIDTH-1:0] acc_r;
  logic               busy_r, done_r, div_zero_r;
  logic               busy_s, done_s, div_zero_s, dz_req_s;
  logic [WIDTH-1:0]   mag_a_s, mag_b_s, quo_fix_s, rem_fix_s;
  logic [WIDTH:0]     sum_s, shift_s, diff_s;
  logic [2*WIDTH-1:0] mult_step_s, div_step_s, prod_fix_s;

  assign dz_req_s = (bus.op == OP_DIV) && (bus.b == {WIDTH{1'b0}});
  assign mag_a_s  = bus.a[WIDTH-1] ? (~bus.a + 1'b1) : bus.a;
  assign mag_b_s  = bus.b[WIDTH-1] ? (~bus.b + 1'b1) : bus.b;

  // Iteration step: acc holds {partial product, multiplier} for mult and
  // {remainder, dividend/quotient} for div; opnd_r is |a| resp. |b|.
  assign sum_s       = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
                       (acc_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
  assign mult_step_s = {sum_s, acc_r[WIDTH-1:1]};
  assign shift_s     = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
  assign diff_s      = shift_s - {1'b0, opnd_r};
  assign div_step_s  = diff_s[WIDTH] ? {shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0}
                                     : {diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};

  assign prod_fix_s = (sign_a_r ^ sign_b_r) ? (~acc_r + 1'b1) : acc_r;
  assign quo_fix_s  = (sign_a_r ^ sign_b_r) ? (~acc_r[WIDTH-1:0] + 1'b1) : acc_r[WIDTH-1:0];
  assign rem_fix_s  = sign_a_r ? (~acc_r[2*WIDTH-1:WIDTH] + 1'b1) : acc_r[2*WIDTH-1:WIDTH];

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= IDLE;
    else        state_r <= state_next_s;
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) state_next_s = dz_req_s ? DONE : CALC;
        else           state_next_s = IDLE;
      end
      CALC: begin
        if (cnt_r == 6'(WIDTH - 1)) state_next_s = FIX;
        else                        state_next_s = CALC;
      end
      FIX:     state_next_s = DONE;
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Output decode, registered below so outputs lag state by one edge
  always_comb begin
    busy_s     = 1'b0;
    done_s     = 1'b0;
    div_zero_s = 1'b0;
    case (state_next_s)
      CALC, FIX: busy_s = 1'b1;
      DONE:      busy_s = (state_r != IDLE);
      default:   busy_s = 1'b0;
    endcase
    if (state_r == DONE) begin
      done_s     = !dz_r;
      div_zero_s = dz_r;
    end else begin
      done_s     = 1'b0;
      div_zero_s = 1'b0;
    end
  end

  // Status output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
    end else begin
      busy_r     <= busy_s;
      done_r     <= done_s;
      div_zero_r <= div_zero_s;
    end
  end

  // Datapath: operand capture, iteration and sign fix-up into HI/LO
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r    <= 6'd0;
      op_r     <= OP_MULT;
      sign_a_r <= 1'b0;
      sign_b_r <= 1'b0;
      dz_r     <= 1'b0;
      opnd_r   <= {WIDTH{1'b0}};
      acc_r    <= {(2*WIDTH){1'b0}};
      hi_r     <= {WIDTH{1'b0}};
      lo_r     <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            dz_r <= dz_req_s;
            if (!dz_req_s) begin
              op_r     <= bus.op;
              sign_a_r <= bus.a[WIDTH-1];
              sign_b_r <= bus.b[WIDTH-1];
              cnt_r    <= 6'd0;
              opnd_r   <= (bus.op == OP_DIV) ? mag_b_s : mag_a_s;
              acc_r    <= {{WIDTH{1'b0}}, (bus.op == OP_DIV) ? mag_a_s : mag_b_s};
            end
          end
        end
        CALC: begin
          acc_r <= (op_r == OP_DIV) ? div_step_s : mult_step_s;
          cnt_r <= cnt_r + 6'd1;
        end
        FIX: begin
          if (op_r == OP_DIV) begin
            hi_r <= rem_fix_s;
            lo_r <= quo_fix_s;
          end else begin
            hi_r <= prod_fix_s[2*WIDTH-1:WIDTH];
            lo_r <= prod_fix_s[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.div_zero = div_zero_r;
  assign bus.hi       = hi_r;
  assign bus.lo       = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: signed mult/div results,
// latency, div-by-zero, ignored start, back-to-back and mid-op reset.
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  mdu_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one request at the current (negedge) time and observes each
  // negedge after edge E0+n until done/div_zero or the cycle bound expires.
  task automatic issue(input logic op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                       input int pulse_at, output int lat, output int busy_cnt,
                       output logic got_done, output logic got_dz);
    bus.start = 1'b1;
    bus.op    = op_i;
    bus.a     = a_i;
    bus.b     = b_i;
    lat       = -1;
    busy_cnt  = 0;
    got_done  = 1'b0;
    got_dz    = 1'b0;
    @(posedge clk);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (n == pulse_at) begin
        bus.start = 1'b1;
        bus.op    = OP_DIV;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.busy) busy_cnt++;
      if (bus.done || bus.div_zero) begin
        got_done = bus.done;
        got_dz   = bus.div_zero;
        lat      = n;
        break;
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.op    = OP_MULT;
    bus.a     = 32'd0;
    bus.b     = 32'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.div_zero} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=000", {bus.busy, bus.done, bus.div_zero});
    end
    checks++;
    if ({bus.hi, bus.lo} !== 64'd0) begin
      failures++;
      $display("FAIL reset_hilo got=%h exp=0", {bus.hi, bus.lo});
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult_signed();
    int lat, bc;
    logic gd, gz;
    issue(OP_MULT, 32'd7, 32'hFFFFFFFD, -1, lat, bc, gd, gz);
    checks++;
    if (lat !== 34 || gd !== 1'b1 || gz !== 1'b0) begin
      failures++;
      $display("FAIL mult_latency got=%0d done=%b dz=%b exp=34 1 0", lat, gd, gz);
    end
    checks++;
    if (bc !== 34) begin
      failures++;
      $display("FAIL mult_busy_cycles got=%0d exp=34", bc);
    end
    checks++;
    if (bus.hi !== 32'hFFFFFFFF || bus.lo !== 32'hFFFFFFEB) begin
      failures++;
      $display("FAIL mult_7x-3 got=%h_%h exp=ffffffff_ffffffeb", bus.hi, bus.lo);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.lo !== 32'hFFFFFFEB) begin
      failures++;
      $display("FAIL done_pulse got done=%b busy=%b lo=%h exp 0 0 ffffffeb", bus.done, bus.busy, bus.lo);
    end
  endtask

  task automatic test_mult_min();
    int lat, bc;
    logic gd, gz;
    issue(OP_MULT, 32'h80000000, 32'h80000000, -1, lat, bc, gd, gz);
    checks++;
    if (lat !== 34 || bus.hi !== 32'h40000000 || bus.lo !== 32'h00000000) begin
      failures++;
      $display("FAIL mult_min got lat=%0d %h_%h exp 34 40000000_00000000", lat, bus.hi, bus.lo);
    end
    @(negedge clk);
  endtask

  task automatic test_div_signed();
    int lat, bc;
    logic gd, gz;
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2, -1, lat, bc, gd, gz);
    checks++;
    if (lat !== 34 || bc !== 34 || gd !== 1'b1) begin
      failures++;
      $display("FAIL div_latency got lat=%0d busy=%0d done=%b exp 34 34 1", lat, bc, gd);
    end
    checks++;
    if (bus.hi !== 32'hFFFFFFFF || bus.lo !== 32'hFFFFFFFD) begin
      failures++;
      $display("FAIL div_-7/2 got=%h_%h exp=ffffffff_fffffffd", bus.hi, bus.lo);
    end
    @(negedge clk);
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, -1, lat, bc, gd, gz);
    checks++;
    if (lat !== 34 || gd !== 1'b1 || gz !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'h80000000) begin
      failures++;
      $display("FAIL div_overflow got lat=%0d done=%b dz=%b %h_%h exp 34 1 0 00000000_80000000",
               lat, gd, gz, bus.hi, bus.lo);
    end
    @(negedge clk);
  endtask

  task automatic test_div_zero();
    int lat, bc;
    logic gd, gz;
    issue(OP_DIV, 32'h56781234, 32'h00010000, -1, lat, bc, gd, gz);
    checks++;
    if (bus.hi !== 32'h00001234 || bus.lo !== 32'h00005678) begin
      failures++;
      $display("FAIL div_setup got=%h_%h exp=00001234_00005678", bus.hi, bus.lo);
    end
    @(negedge clk);
    issue(OP_DIV, 32'd5, 32'd0, -1, lat, bc, gd, gz);
    checks++;
    if (lat !== 1 || gz !== 1'b1 || gd !== 1'b0 || bc !== 0) begin
      failures++;
      $display("FAIL div_zero_flag got lat=%0d dz=%b done=%b busy=%0d exp 1 1 0 0", lat, gz, gd, bc);
    end
    checks++;
    if (bus.hi !== 32'h00001234 || bus.lo !== 32'h00005678) begin
      failures++;
      $display("FAIL div_zero_hold got=%h_%h exp=00001234_00005678", bus.hi, bus.lo);
    end
    @(negedge clk);
    checks++;
    if (bus.div_zero !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL div_zero_pulse got dz=%b done=%b exp 0 0", bus.div_zero, bus.done);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    logic gd, gz;
    issue(OP_MULT, 32'd6, 32'd7, -1, lat, bc, gd, gz);
    checks++;
    if (lat !== 34 || bus.hi !== 32'd0 || bus.lo !== 32'd42) begin
      failures++;
      $display("FAIL b2b_first got lat=%0d %h_%h exp 34 0_2a", lat, bus.hi, bus.lo);
    end
    issue(OP_DIV, 32'd100, 32'hFFFFFFF9, -1, lat, bc, gd, gz);
    checks++;
    if (lat !== 34 || gd !== 1'b1 || bus.hi !== 32'd2 || bus.lo !== 32'hFFFFFFF2) begin
      failures++;
      $display("FAIL b2b_second got lat=%0d done=%b %h_%h exp 34 1 00000002_fffffff2",
               lat, gd, bus.hi, bus.lo);
    end
    @(negedge clk);
  endtask

  task automatic test_ignored_start();
    int lat, bc;
    logic gd, gz;
    issue(OP_MULT, 32'd3, 32'd4, 9, lat, bc, gd, gz);
    checks++;
    if (lat !== 34 || bc !== 34 || bus.hi !== 32'd0 || bus.lo !== 32'd12) begin
      failures++;
      $display("FAIL ignored_start got lat=%0d busy=%0d %h_%h exp 34 34 0_c", lat, bc, bus.hi, bus.lo);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    int lat, bc;
    logic gd, gz;
    bus.start = 1'b1;
    bus.op    = OP_MULT;
    bus.a     = 32'd9;
    bus.b     = 32'd9;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_op_busy got=%b exp=1", bus.busy);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.div_zero} !== 3'b000 || {bus.hi, bus.lo} !== 64'd0) begin
      failures++;
      $display("FAIL async_reset got flags=%b hilo=%h exp 000 0",
               {bus.busy, bus.done, bus.div_zero}, {bus.hi, bus.lo});
    end
    @(negedge clk);
    reset = 1'b1;
    issue(OP_MULT, 32'd2, 32'd2, -1, lat, bc, gd, gz);
    checks++;
    if (lat !== 34 || bus.hi !== 32'd0 || bus.lo !== 32'd4) begin
      failures++;
      $display("FAIL post_reset_mult got lat=%0d %h_%h exp 34 0_4", lat, bus.hi, bus.lo);
    end
    @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_mult_signed();
    test_mult_min();
    test_div_signed();
    test_div_zero();
    test_back_to_back();
    test_ignored_start();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
